// File: rtl/regfile_pkg.sv
// Shared widths and types for the register-file write arbiter and its scoreboard.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 32'd5;
  localparam int unsigned REG_DATA_W = 32'd32;
  localparam int unsigned NUM_REGS   = 32'd32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    PRIO_WB  = 1'b0,
    PRIO_LSU = 1'b1
  } mode_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: claims set a busy bit, LSU writebacks clear it,
// and decode source registers are looked up for a stall.
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  claim_valid,
  input  logic [REG_ADDR_W-1:0] claim_addr,
  input  logic                  clr_valid,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic [REG_ADDR_W-1:0] raddr0,
  input  logic [REG_ADDR_W-1:0] raddr1,
  output logic [NUM_REGS-1:0]   busy_vec,
  output logic                  stall
);

  logic [NUM_REGS-1:0] busy_next;

  // Next busy vector; the set is applied after the clear so a same-cycle claim wins.
  always_comb begin
    busy_next = busy_vec;
    if (clr_valid) begin
      busy_next[clr_addr] = 1'b0;
    end else begin
      busy_next = busy_vec;
    end
    if (claim_valid && (claim_addr != REG_ZERO)) begin
      busy_next[claim_addr] = 1'b1;
    end else begin
      busy_next = busy_next;
    end
  end

  // Busy vector register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_vec <= 32'd0;
    end else begin
      busy_vec <= busy_next;
    end
  end

  assign stall = busy_vec[raddr0] | busy_vec[raddr1];

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between WB and LSU, with a
// starvation guard for LSU and registered rf_* outputs.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [REG_DATA_W-1:0] wb_data,
  output logic                  wb_ready,
  input  logic                  lsu_valid,
  input  logic [REG_ADDR_W-1:0] lsu_addr,
  input  logic [REG_DATA_W-1:0] lsu_data,
  output logic                  lsu_ready,
  input  logic                  claim_valid,
  input  logic [REG_ADDR_W-1:0] claim_addr,
  input  logic [REG_ADDR_W-1:0] raddr0,
  input  logic [REG_ADDR_W-1:0] raddr1,
  output logic                  stall,
  output logic [NUM_REGS-1:0]   busy_vec,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [REG_DATA_W-1:0] rf_wdata,
  output logic                  rf_wren
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

  mode_e                 mode;
  mode_e                 mode_next;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic                  lsu_wait;
  logic                  any_xfer;
  logic [REG_ADDR_W-1:0] sel_addr;
  logic [REG_DATA_W-1:0] sel_data;

  assign wb_ready  = wb_valid  && ((mode == PRIO_WB)  || !lsu_valid);
  assign lsu_ready = lsu_valid && ((mode == PRIO_LSU) || !wb_valid);
  assign lsu_wait  = lsu_valid && !lsu_ready;
  assign any_xfer  = wb_ready || lsu_ready;

  // Mode FSM and starvation counter next-state.
  always_comb begin
    mode_next = mode;
    cnt_next  = cnt;
    case (mode)
      PRIO_WB: begin
        if (lsu_ready) begin
          cnt_next = {CNT_W{1'b0}};
        end else if (lsu_wait) begin
          if (cnt == CNT_LAST) begin
            mode_next = PRIO_LSU;
            cnt_next  = {CNT_W{1'b0}};
          end else begin
            cnt_next = cnt + CNT_W'(1'b1);
          end
        end else begin
          cnt_next = cnt;
        end
      end
      PRIO_LSU: begin
        cnt_next = {CNT_W{1'b0}};
        if (lsu_ready || !lsu_valid) begin
          mode_next = PRIO_WB;
        end else begin
          mode_next = PRIO_LSU;
        end
      end
      default: begin
        mode_next = PRIO_WB;
        cnt_next  = {CNT_W{1'b0}};
      end
    endcase
  end

  // Mode and counter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode <= PRIO_WB;
      cnt  <= {CNT_W{1'b0}};
    end else begin
      mode <= mode_next;
      cnt  <= cnt_next;
    end
  end

  // Winner's address/data; only one of the readies can be high.
  always_comb begin
    if (lsu_ready) begin
      sel_addr = lsu_addr;
      sel_data = lsu_data;
    end else begin
      sel_addr = wb_addr;
      sel_data = wb_data;
    end
  end

  // Write-port output registers; $0 writes complete but never assert wren.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wren  <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= 32'd0;
    end else begin
      rf_wren <= any_xfer && (sel_addr != REG_ZERO);
      if (any_xfer) begin
        rf_waddr <= sel_addr;
        rf_wdata <= sel_data;
      end
    end
  end

  regfile_scoreboard u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .claim_valid (claim_valid),
    .claim_addr  (claim_addr),
    .clr_valid   (lsu_ready),
    .clr_addr    (lsu_addr),
    .raddr0      (raddr0),
    .raddr1      (raddr1),
    .busy_vec    (busy_vec),
    .stall       (stall)
  );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: hand-computed expectations checked
// with immediate assertions.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_addr;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        claim_valid;
  logic [4:0]  claim_addr;
  logic [4:0]  raddr0;
  logic [4:0]  raddr1;
  logic        stall;
  logic [31:0] busy_vec;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_wren;

  int total;
  int passed;
  int lsu_grants;

  regfile_write_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .wb_ready    (wb_ready),
    .lsu_valid   (lsu_valid),
    .lsu_addr    (lsu_addr),
    .lsu_data    (lsu_data),
    .lsu_ready   (lsu_ready),
    .claim_valid (claim_valid),
    .claim_addr  (claim_addr),
    .raddr0      (raddr0),
    .raddr1      (raddr1),
    .stall       (stall),
    .busy_vec    (busy_vec),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .rf_wren     (rf_wren)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    total = 0; passed = 0; lsu_grants = 0;
    rst_n = 1'b0;
    wb_valid = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    lsu_valid = 1'b0; lsu_addr = 5'd0; lsu_data = 32'd0;
    claim_valid = 1'b0; claim_addr = 5'd0; raddr0 = 5'd0; raddr1 = 5'd0;

    // Reset state
    tick(); tick();
    chk("rst_wren", rf_wren, 32'd0);
    chk("rst_waddr", rf_waddr, 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_busy", busy_vec, 32'd0);
    chk("rst_stall", stall, 32'd0);
    rst_n = 1'b1;

    // Single WB write
    tick();
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    #1;
    chk("wb1_ready", wb_ready, 32'd1);
    chk("wb1_lsu_ready", lsu_ready, 32'd0);
    chk("wb1_wren_before", rf_wren, 32'd0);
    tick();
    chk("wb1_wren", rf_wren, 32'd1);
    chk("wb1_waddr", rf_waddr, 32'd5);
    chk("wb1_wdata", rf_wdata, 32'hDEADBEEF);
    wb_valid = 1'b0;
    tick();
    chk("wb1_wren_drop", rf_wren, 32'd0);

    // Contention: LSU starves 4 cycles, wins cycle 4, WB resumes cycle 5
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 4) chk("cont_rf_wb_addr", rf_waddr, 32'd12);
      if (k == 5) begin
        chk("cont_rf_lsu_wren", rf_wren, 32'd1);
        chk("cont_rf_lsu_addr", rf_waddr, 32'd7);
        chk("cont_rf_lsu_data", rf_wdata, 32'h1234_5678);
      end
      wb_valid = 1'b1; wb_addr = 5'd12; wb_data = 32'h0000_0C0C;
      lsu_valid = (lsu_grants == 0) ? 1'b1 : 1'b0;
      lsu_addr = 5'd7; lsu_data = 32'h1234_5678;
      #1;
      chk($sformatf("cont_wb_ready_%0d", k), wb_ready, (k == 4) ? 32'd0 : 32'd1);
      chk($sformatf("cont_lsu_ready_%0d", k), lsu_ready, (k == 4) ? 32'd1 : 32'd0);
      if (lsu_ready) lsu_grants++;
    end
    chk("cont_lsu_grants", lsu_grants, 32'd1);
    tick();
    wb_valid = 1'b0; lsu_valid = 1'b0;

    // Scoreboard claim and LSU release
    tick();
    claim_valid = 1'b1; claim_addr = 5'd9; raddr0 = 5'd9;
    #1;
    chk("sb_stall_same_cycle", stall, 32'd0);
    tick();
    claim_valid = 1'b0;
    #1;
    chk("sb_stall_r0", stall, 32'd1);
    chk("sb_busy9", busy_vec, 32'h0000_0200);
    raddr0 = 5'd0; raddr1 = 5'd9;
    #1;
    chk("sb_stall_r1", stall, 32'd1);
    lsu_valid = 1'b1; lsu_addr = 5'd9; lsu_data = 32'hCAFE_0009;
    #1;
    chk("sb_lsu_ready", lsu_ready, 32'd1);
    chk("sb_stall_during_xfer", stall, 32'd1);
    tick();
    lsu_valid = 1'b0;
    #1;
    chk("sb_stall_released", stall, 32'd0);
    chk("sb_wren", rf_wren, 32'd1);
    chk("sb_waddr", rf_waddr, 32'd9);
    chk("sb_busy_clear", busy_vec, 32'd0);
    raddr1 = 5'd0;

    // Same-cycle set and clear of $3: set wins
    tick();
    claim_valid = 1'b1; claim_addr = 5'd3;
    lsu_valid = 1'b1; lsu_addr = 5'd3; lsu_data = 32'h0000_0033;
    #1;
    chk("sc_lsu_ready", lsu_ready, 32'd1);
    tick();
    claim_valid = 1'b0;
    #1;
    chk("sc_busy3", busy_vec, 32'h0000_0008);
    chk("sc_wren", rf_wren, 32'd1);
    chk("sc_waddr", rf_waddr, 32'd3);
    tick();
    lsu_valid = 1'b0;
    #1;
    chk("sc_busy_cleared", busy_vec, 32'd0);

    // $0 handling
    tick();
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    #1;
    chk("z_wb_ready", wb_ready, 32'd1);
    tick();
    wb_valid = 1'b0;
    claim_valid = 1'b1; claim_addr = 5'd0;
    #1;
    chk("z_wren", rf_wren, 32'd0);
    tick();
    claim_valid = 1'b0;
    #1;
    chk("z_busy", busy_vec, 32'd0);

    // Build busy=0x210, rf_wren=1 and mode=PRIO_LSU, then reset mid-cycle
    tick();
    claim_valid = 1'b1; claim_addr = 5'd4;
    wb_valid = 1'b1; wb_addr = 5'd20; wb_data = 32'hA5A5_A5A5;
    lsu_valid = 1'b1; lsu_addr = 5'd21; lsu_data = 32'h5A5A_5A5A;
    raddr0 = 5'd4;
    tick();
    claim_addr = 5'd9;
    tick();
    claim_valid = 1'b0;
    tick();
    tick();
    chk("ar_pre_wren", rf_wren, 32'd1);
    chk("ar_pre_waddr", rf_waddr, 32'd20);
    chk("ar_pre_busy", busy_vec, 32'h0000_0210);
    chk("ar_pre_stall", stall, 32'd1);
    chk("ar_pre_lsu_prio", lsu_ready, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_wren", rf_wren, 32'd0);
    chk("ar_waddr", rf_waddr, 32'd0);
    chk("ar_wdata", rf_wdata, 32'd0);
    chk("ar_busy", busy_vec, 32'd0);
    chk("ar_stall", stall, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("ar_post_wb_ready", wb_ready, 32'd1);
    chk("ar_post_lsu_ready", lsu_ready, 32'd0);
    tick();
    chk("ar_post_wren", rf_wren, 32'd1);
    chk("ar_post_waddr", rf_waddr, 32'd20);
    wb_valid = 1'b0; lsu_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two writers: the pipeline writeback stage (WB) and the load/long-latency unit (LSU).
- Keeps a 32-entry pending-write scoreboard so decode can stall on registers that are still outstanding.
- Sits between the writeback/LSU logic and the register file write port.
- Drives the register file's waddr, wdata and wren from registered outputs.

Parameters:
- STARVE_LIMIT, 4: number of consecutive cycles LSU may wait with valid high before it takes priority.
- CNT_W, 3: width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wb_valid  in  1  WB write request.
- wb_addr  in  5  WB destination register.
- wb_data  in  32  WB write data.
- wb_ready  out  1  WB request accepted this cycle.
- lsu_valid  in  1  LSU write request.
- lsu_addr  in  5  LSU destination register.
- lsu_data  in  32  LSU write data.
- lsu_ready  out  1  LSU request accepted this cycle.
- claim_valid  in  1  decode issues an instruction with a long-latency destination.
- claim_addr  in  5  register being claimed.
- raddr0  in  5  decode source register 0.
- raddr1  in  5  decode source register 1.
- stall  out  1  raddr0 or raddr1 is marked busy.
- busy_vec  out  32  scoreboard contents, for debug.
- rf_waddr  out  5  to register file waddr.
- rf_wdata  out  32  to register file wdata.
- rf_wren  out  1  to register file wren.

Behaviour:
- Reset is asynchronous and active-low on rst_n. Reset values: rf_wren=0, rf_waddr=0, rf_wdata=0, busy_vec=0, starvation counter=0, mode=PRIO_WB.
- Handshake: a transfer occurs when valid && ready. A requester holds valid, addr and data stable until ready is seen. At most one transfer per cycle.
- wb_ready = wb_valid && (mode==PRIO_WB || !lsu_valid). This is combinational.
- lsu_ready = lsu_valid && (mode==PRIO_LSU || !wb_valid). This is combinational.
- Latency: an accepted request appears on rf_* one cycle later. rf_wren is high for exactly one cycle per transfer.
- Register $0: a transfer with addr==0 completes the handshake but leaves rf_wren=0 the next cycle.
- Mode FSM, PRIO_WB:
  - Counter increments in each cycle where lsu_valid && !lsu_ready.
  - When the counter equals STARVE_LIMIT-1 and LSU waits again, go to PRIO_LSU and clear the counter.
  - Any LSU transfer clears the counter.
- Mode FSM, PRIO_LSU:
  - Return to PRIO_WB on an LSU transfer or when lsu_valid drops.
  - WB is blocked only while lsu_valid is high.
- Scoreboard set: claim_valid with claim_addr!=0 sets busy[claim_addr] at the next edge. Claims of $0 are ignored.
- Scoreboard clear: an LSU transfer clears busy[lsu_addr]. WB transfers never touch the scoreboard, because WB results are bypassed elsewhere.
- Simultaneous set and clear of the same address: set wins.
- Re-claiming an already-busy register keeps it busy (no counting).
- stall = busy[raddr0] | busy[raddr1]. This is combinational from the registered busy_vec. It does not include a clear happening in the same cycle, so the stall releases one cycle after the LSU transfer, aligned with rf_wren.
- Reset mid-operation: all pending claims are dropped and any in-flight rf_wren is cancelled immediately (asynchronous).

Decomposition:
- Shared package regfile_pkg holds:
  - REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32, REG_ZERO=5'd0.
  - The mode enum {PRIO_WB, PRIO_LSU}.
- One natural sub-module: regfile_scoreboard. It contains the busy vector, the set/clear logic and the stall lookup.
- Arbitration, the FSM and the output registers stay in the top level.

Test Plan:
- Single WB write: wb_valid, addr=5, data=32'hDEADBEEF → wb_ready=1 the same cycle; next cycle rf_wren=1, rf_waddr=5, rf_wdata=32'hDEADBEEF; rf_wren=0 the cycle after.
- Contention: both valid for 10 cycles, lsu addr=7, STARVE_LIMIT=4 → WB wins cycles 0–3, LSU is granted on cycle 4, WB resumes on cycle 5; lsu_ready is high for exactly one cycle.
- Scoreboard: claim addr=9; next cycle raddr0=9 gives stall=1. LSU writes addr=9 → stall=0 on the cycle rf_wren=1 with rf_waddr=9.
- Same-cycle set and clear: claim addr=3 while an LSU transfer to addr=3 is accepted → busy_vec[3]=1 afterward; rf_wren=1 with rf_waddr=3.
- $0 handling: WB writes addr=0 → wb_ready=1 and rf_wren stays 0. Claim addr=0 → busy_vec stays 0.
- Async reset: assert rst_n=0 mid-cycle with busy_vec=32'h0000_0210 and rf_wren=1 → outputs go to 0 immediately without a clock edge; after release, mode=PRIO_WB.
